// File: rtl/jk_pkg.sv
// Shared JK flip-flop command encodings and next-state helper.
package jk_pkg;

   typedef logic [1:0] jk_cmd_t;

   // {J,K} ordering
   localparam jk_cmd_t JK_HOLD = 2'b00;
   localparam jk_cmd_t JK_SET  = 2'b10;
   localparam jk_cmd_t JK_CLR  = 2'b01;
   localparam jk_cmd_t JK_TOG  = 2'b11;

   function automatic logic jk_next(input logic q, input jk_cmd_t cmd);
      logic n;
      case (cmd)
         JK_HOLD: n = q;
         JK_SET:  n = 1'b1;
         JK_CLR:  n = 1'b0;
         default: n = ~q;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop with synchronous active-high reset; one-edge latency.
module jk_ff_sync
   import jk_pkg::*;
(
   input  logic Clk,
   input  logic Rst,
   input  logic J,
   input  logic K,
   output logic Q
);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Q <= 1'b0;
      end else begin
         Q <= jk_next(Q, jk_cmd_t'({J, K}));
      end
   end

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo up/down counter built from JK flip-flops, with parallel load and sticky illegal-load flag.
// Define JK_CNT_SATURATE_EN to hold at the ends of the range instead of wrapping.
module jk_sync_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
)(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Jx,
   output logic [WIDTH-1:0] Kx,
   output logic             Tc,
   output logic             Err
);

   // One extra bit so MODULUS == 2**WIDTH is representable
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_inc;
   logic [WIDTH-1:0] w_dec;
   logic             w_load_ok;
   logic             w_at_max;
   logic             w_at_zero;
   logic             r_err;

   assign w_load_ok = ({1'b0, D} < MOD_EXT);
   assign w_at_max  = (w_q == Q_MAX);
   assign w_at_zero = (w_q == '0);

`ifdef JK_CNT_SATURATE_EN
   assign w_inc = w_at_max  ? Q_MAX : w_q + ONE;
   assign w_dec = w_at_zero ? '0    : w_q - ONE;
`else
   assign w_inc = w_at_max  ? '0    : w_q + ONE;
   assign w_dec = w_at_zero ? Q_MAX : w_q - ONE;
`endif

   always_comb begin
      w_next = w_q;
      if (Rst) begin
         w_next = '0;
      end else if (Load) begin
         w_next = w_load_ok ? D : '0;
      end else if (En) begin
         w_next = Up ? w_inc : w_dec;
      end
   end

   // Set only bits rising, clear only bits falling; everything else holds
   assign Jx = ~w_q & w_next;
   assign Kx = w_q & ~w_next;

   assign Tc = ~Rst & En & ~Load & ((Up & w_at_max) | (~Up & w_at_zero));

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_err <= 1'b0;
      end else if (Load && !w_load_ok) begin
         r_err <= 1'b1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_ff_sync u_ff (
         .Clk (Clk),
         .Rst (Rst),
         .J   (Jx[i]),
         .K   (Kx[i]),
         .Q   (w_q[i])
      );
   end

   assign Q   = w_q;
   assign Err = r_err;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for jk_sync_counter at WIDTH=4, MODULUS=10.
module tb_jk_sync_counter;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       En;
   logic       Up;
   logic       Load;
   logic [3:0] D;
   logic [3:0] Q;
   logic [3:0] Jx;
   logic [3:0] Kx;
   logic       Tc;
   logic       Err;

   int n_chk  = 0;
   int n_fail = 0;

   jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .Clk  (Clk),
      .Rst  (Rst),
      .En   (En),
      .Up   (Up),
      .Load (Load),
      .D    (D),
      .Q    (Q),
      .Jx   (Jx),
      .Kx   (Kx),
      .Tc   (Tc),
      .Err  (Err)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic rst, input logic ld, input logic [3:0] d,
                        input logic en, input logic up);
      Rst = rst; Load = ld; D = d; En = en; Up = up;
      #1;
   endtask

   initial begin
      int q_exp;
      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      step();
      check("reset_q", 32'(Q), 32'd0);
      check("reset_err", 32'(Err), 32'd0);

      // Reach Q=7 with Err set
      drive(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
      step();
      drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
      step();
      check("pre_q7", 32'(Q), 32'd7);
      check("pre_err1", 32'(Err), 32'd1);

      // Reset during count: clear excitation, Tc low
      drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
      check("rst_jx", 32'(Jx), 32'd0);
      check("rst_kx", 32'(Kx), 32'd7);
      check("rst_tc", 32'(Tc), 32'd0);
      step();
      check("rst_q", 32'(Q), 32'd0);
      check("rst_err", 32'(Err), 32'd0);
      check("rst_tc_after", 32'(Tc), 32'd0);

      // Count up 12 edges with wrap
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      q_exp = 0;
      for (int i = 0; i < 12; i++) begin
         check($sformatf("up_tc_%0d", i), 32'(Tc), (q_exp == 9) ? 32'd1 : 32'd0);
         if (q_exp == 9) begin
            check("wrap_jx", 32'(Jx), 32'h0);
            check("wrap_kx", 32'(Kx), 32'h9);
         end
         step();
         q_exp = (q_exp + 1) % 10;
         check($sformatf("up_q_%0d", i), 32'(Q), 32'(q_exp));
      end

      // Count down from 0
      drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      step();
      check("ld0_q", 32'(Q), 32'd0);
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check("dn_tc", 32'(Tc), 32'd1);
      step();
`ifdef JK_CNT_SATURATE_EN
      check("dn_q", 32'(Q), 32'd0);
`else
      check("dn_q", 32'(Q), 32'd9);
`endif

      // Terminal count suppressed by Load
      drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
      step();
      check("ld9_q", 32'(Q), 32'd9);
      check("tc_load_mask", 32'(Tc), 32'd0);
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      check("tc_up9", 32'(Tc), 32'd1);
      step();
`ifdef JK_CNT_SATURATE_EN
      check("up_end_q", 32'(Q), 32'd9);
`else
      check("up_end_q", 32'(Q), 32'd0);
`endif

      // Legal then illegal load
      drive(1'b0, 1'b1, 4'd6, 1'b1, 1'b1);
      step();
      check("ld6_q", 32'(Q), 32'd6);
      check("ld6_err", 32'(Err), 32'd0);
      drive(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
      step();
      check("ld12_q", 32'(Q), 32'd0);
      check("ld12_err", 32'(Err), 32'd1);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("err_sticky_%0d", i), 32'(Err), 32'd1);
         check($sformatf("hold_q_%0d", i), 32'(Q), 32'd0);
      end
      check("hold_jx", 32'(Jx), 32'd0);
      check("hold_kx", 32'(Kx), 32'd0);

      // Reset overrides Load
      drive(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
      step();
      check("rst_ld_q", 32'(Q), 32'd0);
      check("rst_ld_err", 32'(Err), 32'd0);

      // Tc forced low during reset even at Q=9 counting up
      drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
      check("rst_tc_q9", 32'(Tc), 32'd0);
      step();
      check("rst_q9_q", 32'(Q), 32'd0);

      // Direction flips every edge from 4
      drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
      step();
      check("ld4_q", 32'(Q), 32'd4);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 4'd0, 1'b1, (k % 2 == 0));
         step();
         check($sformatf("updn_q_%0d", k), 32'(Q), (k % 2 == 0) ? 32'd5 : 32'd4);
         check($sformatf("updn_b0_%0d", k), 32'(Q[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
